// File: rtl/cim_pkg.sv
// Shared types and helpers for the CIM crossbar tile and the fc_layer units built around it.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } cim_tile_state_t;

  // Right-shift an unsigned accumulator, then clamp it to the largest width-bit value.
  function automatic logic [31:0] sat_shift(input logic [31:0] acc,
                                            input int unsigned shift,
                                            input int unsigned width);
    logic [31:0] shifted;
    logic [31:0] max_val;
    shifted = acc >> shift;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (shifted > max_val) ? max_val : shifted;
  endfunction

endpackage

// File: rtl/cim_xbar_col_acc.sv
// One crossbar column: accumulates the selected row inputs, then latches a shifted/saturated result.
module cim_xbar_col_acc
  import cim_pkg::*;
#(
  parameter int unsigned datatype_size = 8,
  parameter int unsigned ACC_W         = 17,
  parameter int unsigned out_shift     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     mac_en_i,
  input  logic                     w_bit_i,
  input  logic [datatype_size-1:0] x_i,
  input  logic                     latch_i,
  output logic [datatype_size-1:0] res_o
);

  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [datatype_size-1:0] res_q, res_d;

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    if (clr_i)
      acc_d = '0;
    else if (mac_en_i && w_bit_i)
      acc_d = acc_q + ACC_W'(x_i);
    if (latch_i)
      res_d = datatype_size'(sat_shift(32'(acc_q), out_shift, datatype_size));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/cim_xbar_tile.sv
// Binary CIM crossbar tile: buffered inputs and weights, row-serial column MACs, registered result read port.
module cim_xbar_tile
  import cim_pkg::*;
#(
  parameter int unsigned datatype_size = 8,
  parameter int unsigned xbar_size     = 256,
  parameter int unsigned extra_latency = 4,
  parameter int unsigned out_shift     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_wprog_en,
  input  logic [$clog2(xbar_size)-1:0] i_wprog_row,
  input  logic [xbar_size-1:0]         i_wprog_bits,
  input  logic                         i_start,
  output logic                         o_busy,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_rd_data
);

  localparam int unsigned AW    = $clog2(xbar_size);
  localparam int unsigned ACC_W = datatype_size + AW + 1;
  localparam int unsigned DCW   = $clog2(extra_latency + 2);

  cim_tile_state_t          state_q, state_d;
  logic [AW-1:0]            row_q, row_d;
  logic [DCW-1:0]           drain_q, drain_d;
  logic                     acc_clr, mac_en, res_latch;

  logic [datatype_size-1:0] in_buf_q [xbar_size];
  logic [xbar_size-1:0]     w_q      [xbar_size];
  logic [datatype_size-1:0] res      [xbar_size];
  logic [datatype_size-1:0] rd_data_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    drain_d   = drain_q;
    acc_clr   = 1'b0;
    mac_en    = 1'b0;
    res_latch = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          acc_clr = 1'b1;
          row_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        mac_en = 1'b1;
        row_d  = row_q + 1'b1;
        if (row_q == AW'(xbar_size - 1)) begin
          drain_d = '0;
          state_d = (extra_latency == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == DCW'(extra_latency - 1))
          state_d = DONE;
        else
          drain_d = drain_q + 1'b1;
      end
      DONE: begin
        res_latch = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      drain_q <= drain_d;
    end
  end

  // Buffers only accept writes while idle, so a compute sees a frozen snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(xbar_size); i++) begin
        in_buf_q[i] <= '0;
        w_q[i]      <= '0;
      end
    end else if (state_q == IDLE) begin
      if (i_wr_en)    in_buf_q[i_wr_addr] <= i_wr_data;
      if (i_wprog_en) w_q[i_wprog_row]    <= i_wprog_bits;
    end
  end

  for (genvar c = 0; c < int'(xbar_size); c++) begin : g_col
    cim_xbar_col_acc #(
      .datatype_size(datatype_size),
      .ACC_W        (ACC_W),
      .out_shift    (out_shift)
    ) u_col (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (acc_clr),
      .mac_en_i(mac_en),
      .w_bit_i (w_q[row_q][c]),
      .x_i     (in_buf_q[row_q]),
      .latch_i (res_latch),
      .res_o   (res[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= res[i_rd_addr];
  end

  assign o_busy    = (state_q != IDLE);
  assign o_rd_data = rd_data_q;

endmodule
